// File: rtl/interrupt_pkg.sv
// Shared defaults and types for the interrupt handler block.
`default_nettype none

package interrupt_pkg;

   localparam int DEFAULT_WIDTH         = 16;
   localparam int DEFAULT_ADDRESS_WIDTH = 32;
   localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] DEFAULT_IVT_BASE = 32'h0000_0000;
   localparam int DEFAULT_ENTRY_SHIFT   = 2;

   localparam int IDX_W = $clog2(DEFAULT_WIDTH);

   typedef logic [IDX_W-1:0] line_idx_t;

endpackage : interrupt_pkg

`default_nettype wire

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of vec (bit 0 highest priority).
`default_nettype none

module interrupt_priority_encoder #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule : interrupt_priority_encoder

`default_nettype wire

// File: rtl/interrupt_handler.sv
// Pending-interrupt register, fixed-priority arbitration and vector address generation.
// Optional macro INTERRUPT_HANDLER_MASK_EN adds a per-line interruptMask input.
`default_nettype none

module interrupt_handler
   import interrupt_pkg::*;
#(
   parameter int                         WIDTH         = DEFAULT_WIDTH,
   parameter int                         ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter logic [ADDRESS_WIDTH-1:0]   IVT_BASE      = ADDRESS_WIDTH'(DEFAULT_IVT_BASE),
   parameter int                         ENTRY_SHIFT   = DEFAULT_ENTRY_SHIFT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         externalInterrupt,
   input  logic [WIDTH-1:0]         setInterrupt,
   input  logic [WIDTH-1:0]         resetInterrupt,
`ifdef INTERRUPT_HANDLER_MASK_EN
   input  logic [WIDTH-1:0]         interruptMask,
`endif
   input  logic                     PSWI,
   output logic                     interruptRequest,
   output logic [ADDRESS_WIDTH-1:0] address
);

   localparam int LINE_IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0]      pending;
   logic [WIDTH-1:0]      eligible;
   logic                  win_valid;
   logic [LINE_IDX_W-1:0] win_idx;
   logic [ADDRESS_WIDTH-1:0] win_offset;

   // Set and external sources override an acknowledge on the same line.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= externalInterrupt | setInterrupt | (pending & ~resetInterrupt);
      end
   end

`ifdef INTERRUPT_HANDLER_MASK_EN
   assign eligible = pending & ~interruptMask;
`else
   assign eligible = pending;
`endif

   interrupt_priority_encoder #(
      .WIDTH (WIDTH),
      .IDX_W (LINE_IDX_W)
   ) u_priority_encoder (
      .vec   (eligible),
      .valid (win_valid),
      .index (win_idx)
   );

   assign win_offset       = ADDRESS_WIDTH'(win_idx) << ENTRY_SHIFT;
   assign address          = win_valid ? (IVT_BASE + win_offset) : IVT_BASE;
   assign interruptRequest = PSWI & win_valid;

endmodule : interrupt_handler

`default_nettype wire

// File: tb/tb_interrupt_handler.sv
// Self-checking bench for interrupt_handler: vector table plus hand-written corner sequences.
`default_nettype none

module tb_interrupt_handler;

   localparam int WIDTH = 16;
   localparam int AW    = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic [WIDTH-1:0] externalInterrupt;
   logic [WIDTH-1:0] setInterrupt;
   logic [WIDTH-1:0] resetInterrupt;
   logic [WIDTH-1:0] interruptMask;
   logic            PSWI;
   logic            interruptRequest;
   logic [AW-1:0]   address;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   interrupt_handler #(
      .WIDTH         (WIDTH),
      .ADDRESS_WIDTH (AW),
      .IVT_BASE      (32'h0000_0000),
      .ENTRY_SHIFT   (2)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .externalInterrupt (externalInterrupt),
      .setInterrupt      (setInterrupt),
      .resetInterrupt    (resetInterrupt),
`ifdef INTERRUPT_HANDLER_MASK_EN
      .interruptMask     (interruptMask),
`endif
      .PSWI              (PSWI),
      .interruptRequest  (interruptRequest),
      .address           (address)
   );

   typedef struct {
      string            name;
      logic [WIDTH-1:0] ext;
      logic [WIDTH-1:0] set;
      logic [WIDTH-1:0] rst;
      logic             pswi;
      logic             exp_req;
      logic [AW-1:0]    exp_addr;
   } vec_t;

   typedef struct {
      string         name;
      logic          req;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Pop the oldest expectation and compare against the current outputs.
   task automatic compare_outputs();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      check({e.name, ".req"},  AW'(interruptRequest), AW'(e.req));
      check({e.name, ".addr"}, address,               e.addr);
   endtask

   task automatic drive(input logic [WIDTH-1:0] ext, input logic [WIDTH-1:0] set,
                        input logic [WIDTH-1:0] rst, input logic pswi);
      @(negedge clock);
      externalInterrupt = ext;
      setInterrupt      = set;
      resetInterrupt    = rst;
      PSWI              = pswi;
   endtask

   task automatic step(input vec_t v);
      exp_t e;
      drive(v.ext, v.set, v.rst, v.pswi);
      e.name = v.name;
      e.req  = v.exp_req;
      e.addr = v.exp_addr;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_outputs();
   endtask

   task automatic add(input string n, input logic [WIDTH-1:0] ext, input logic [WIDTH-1:0] set,
                      input logic [WIDTH-1:0] rst, input logic pswi,
                      input logic req, input logic [AW-1:0] addr);
      vec_t v;
      v.name = n; v.ext = ext; v.set = set; v.rst = rst; v.pswi = pswi;
      v.exp_req = req; v.exp_addr = addr;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;

      add("idle",         16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h00);
      add("ext5",         16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b1, 32'h14);
      add("ext1_beats5",  16'h0022, 16'h0000, 16'h0000, 1'b1, 1'b1, 32'h04);
      add("pswi_off",     16'h0022, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h04);
      add("ext_low",      16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h04);
      add("pswi_on",      16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 32'h04);
      add("ack1",         16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b1, 32'h14);
      add("ack5",         16'h0000, 16'h0000, 16'h0020, 1'b1, 1'b0, 32'h00);
      add("set6",         16'h0000, 16'h0040, 16'h0000, 1'b1, 1'b1, 32'h18);
      add("set1",         16'h0000, 16'h0002, 16'h0000, 1'b1, 1'b1, 32'h04);
      add("set3_rst3",    16'h0000, 16'h0008, 16'h000A, 1'b1, 1'b1, 32'h0C);
      add("ack3",         16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b1, 32'h18);
      add("ext2_rst2",    16'h0004, 16'h0000, 16'h0004, 1'b1, 1'b1, 32'h08);
      add("ext2_held",    16'h0004, 16'h0000, 16'h0004, 1'b1, 1'b1, 32'h08);
      add("ack2_6",       16'h0000, 16'h0000, 16'h0044, 1'b1, 1'b0, 32'h00);
      add("ack_nonpend",  16'h0000, 16'h0000, 16'h0200, 1'b1, 1'b0, 32'h00);
      add("set15",        16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1, 32'h3C);
      add("set0",         16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b1, 32'h00);
      add("ack0_15",      16'h0000, 16'h0000, 16'h8001, 1'b1, 1'b0, 32'h00);

      reset             = 1'b1;
      externalInterrupt = '0;
      setInterrupt      = '0;
      resetInterrupt    = '0;
      interruptMask     = '0;
      PSWI              = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      e.name = "reset"; e.req = 1'b0; e.addr = 32'h0;
      sb.push_back(e);
      compare_outputs();
      @(negedge clock);
      reset = 1'b0;

      foreach (tbl[i]) step(tbl[i]);

      // PSWI gates the request combinationally, with no clock edge in between.
      drive(16'h0000, 16'h0010, 16'h0000, 1'b1);
      @(posedge clock); #1;
      check("set4.addr", address, 32'h10);
      check("set4.req",  AW'(interruptRequest), 32'h1);
      drive(16'h0000, 16'h0000, 16'h0000, 1'b1);
      #2 PSWI = 1'b0;
      #1;
      check("pswi_comb.req", AW'(interruptRequest), 32'h0);
      PSWI = 1'b1;
      #1;
      check("pswi_comb_back.req", AW'(interruptRequest), 32'h1);

      // Reset beats pending lines and an active set.
      drive(16'h0000, 16'h00F0, 16'h0000, 1'b1);
      reset = 1'b1;
      drive(16'h0000, 16'hFFFF, 16'h0000, 1'b1);
      e.name = "reset_prio"; e.req = 1'b0; e.addr = 32'h0;
      sb.push_back(e);
      @(posedge clock); #1;
      compare_outputs();
      @(negedge clock);
      reset        = 1'b0;
      setInterrupt = '0;

`ifdef INTERRUPT_HANDLER_MASK_EN
      drive(16'h0000, 16'h0042, 16'h0000, 1'b1);
      interruptMask = 16'h0002;
      @(posedge clock); #1;
      check("mask1.addr", address, 32'h18);
      check("mask1.req",  AW'(interruptRequest), 32'h1);
      drive(16'h0000, 16'h0000, 16'h0000, 1'b1);
      interruptMask = 16'h0042;
      #1;
      check("mask_all.req",  AW'(interruptRequest), 32'h0);
      check("mask_all.addr", address, 32'h0);
      interruptMask = 16'h0000;
      #1;
      check("unmask.addr", address, 32'h04);
`endif

      check("sb_drained", AW'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_interrupt_handler

`default_nettype wire

// File: doc/interrupt_handler.md
Name: interrupt_handler

Overview:
Collects up to WIDTH interrupt sources into a pending register. Sources are external hardware lines and software set requests. Pending bits are cleared individually by the CPU's acknowledge (reset) requests. The block arbitrates pending lines by fixed priority, gates the request with the PSW interrupt-enable bit (PSWI), and presents the handler vector address of the winning line to the CPU control unit.

Parameters:
WIDTH, 16, number of interrupt lines (>=2); line index width IDX_W = $clog2(WIDTH)
ADDRESS_WIDTH, 32, width of the vector address output
IVT_BASE, 0, base address of the interrupt vector table
ENTRY_SHIFT, 2, log2 of the vector-table entry size in bytes (default 4-byte entries)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
externalInterrupt  input  WIDTH  hardware interrupt lines, level-sampled each cycle
setInterrupt  input  WIDTH  software request, per-bit set of pending
resetInterrupt  input  WIDTH  acknowledge, per-bit clear of pending
PSWI  input  1  global interrupt enable from PSW
interruptRequest  output  1  interrupt to be taken by CPU
address  output  ADDRESS_WIDTH  vector address of highest-priority pending line

Behaviour:
- Interface: one clock, reset is synchronous and active-high.
- State: pending[WIDTH-1:0], the only register in the block.
- Reset (reset=1 at a rising edge): pending <= 0. Consequently interruptRequest=0 and address=IVT_BASE. Reset has priority over all other inputs.
- Per-cycle update for each bit i: pending[i] <= externalInterrupt[i] | setInterrupt[i] | (pending[i] & ~resetInterrupt[i]).
- Simultaneous set/external and reset on the same bit: set wins, so no request is lost.
- A level-held externalInterrupt therefore re-pends its line on every cycle it stays high, even after acknowledge.
- Latency: an input asserted before edge N is reflected in the outputs immediately after edge N (1 cycle). Outputs are combinational from pending (and PSWI).
- Arbitration: fixed priority, lowest index wins (line 0 highest). The winner is idx = lowest i with pending[i]=1.
- address = IVT_BASE + (idx << ENTRY_SHIFT), computed modulo 2^ADDRESS_WIDTH.
- If no line is pending, address = IVT_BASE.
- The address reflects pending lines regardless of PSWI.
- interruptRequest = PSWI & (|pending), combinational in PSWI (no extra cycle).
- PSWI=0 does not stop latching; lines become pending while disabled and are requested once PSWI returns to 1.
- Bits of setInterrupt/resetInterrupt for non-pending lines: a set pends the line, a reset is a no-op.
- X on inputs is not tolerated; the bench drives all inputs to known values from reset.

Optional Feature:
Macro INTERRUPT_HANDLER_MASK_EN.
- Defined: adds input port interruptMask [WIDTH-1:0]. A masked line (mask bit 1) still latches into pending but is excluded from arbitration and from interruptRequest. Unmasking a still-pending line makes it eligible on the same cycle (combinational).
- Undefined: no interruptMask port; all pending lines participate.

Decomposition:
- Shared package interrupt_pkg holds: default WIDTH/ADDRESS_WIDTH, IVT_BASE, ENTRY_SHIFT, and a typedef for the line index (logic [IDX_W-1:0]).
- One natural sub-module, interrupt_priority_encoder: input vector WIDTH, outputs valid and index (lowest set bit), purely combinational.
- The vector-address computation and pending register stay in interrupt_handler.

Test Plan:
- Reset, then all inputs 0 -> pending=0, interruptRequest=0, address=0x00000000.
- PSWI=1, externalInterrupt[5]=1 -> next cycle interruptRequest=1, address=0x14. Then add externalInterrupt[1]=1 -> address=0x04 (line 1 beats 5).
- PSWI=0 with lines 1 and 5 pending -> interruptRequest=0 immediately, address stays 0x04. Lower externals, then PSWI=1 -> request=1, address=0x04 (pending retained).
- resetInterrupt[1]=1 -> address=0x14. Then resetInterrupt[5]=1 -> request=0, address=0x00.
- setInterrupt[6]=1 -> address=0x18. Then setInterrupt[1]=1 -> address=0x04. setInterrupt[3] and resetInterrupt[3] in the same cycle -> bit 3 pending.
- Reset asserted with several lines pending and setInterrupt active -> pending=0, request=0 next edge. With INTERRUPT_HANDLER_MASK_EN defined, interruptMask[1]=1 with lines 1 and 6 pending -> address=0x18.
